prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/word_packer.sv | 45 ++++
 rtl/prog_loader.sv | 151 +++++++++++++++
 tb/tb_prog_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader, instruction memory and CPU control.
package prog_loader_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ADDR_W_DEFAULT = 16;
  localparam int unsigned CNT_W          = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WRITE  = 3'd2,
    S_CHECK  = 3'd3,
    S_FINISH = 3'd4
  } loader_state_e;

endpackage

// File: rtl/word_packer.sv
// Packs four bytes big-endian into one 32-bit word; flags the 4th byte.
module word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word_next,
  output logic              word_done
);

  logic [DATA_W-1:0] word_q, word_d;
  logic [1:0]        cnt_q, cnt_d;

  // Word value including the byte being accepted now; first byte ends in [31:24].
  assign word_next = {word_q[DATA_W-9:0], byte_in};
  assign word_done = shift_en && (cnt_q == 2'd3);

  // Next-state for the shift register and byte counter.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      word_d = word_next;
      cnt_d  = cnt_q + 2'd1;
    end
  end

  // Register the packer state; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams program bytes into instruction memory, one word write per 4 bytes,
// then verifies a trailing XOR checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [7:0]        chk_q, chk_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              pack_clear;
  logic              pack_shift;
  logic [DATA_W-1:0] word_next;
  logic              word_done;

  assign accept = byte_valid && byte_ready_q;

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pack_clear),
    .shift_en  (pack_shift),
    .byte_in   (byte_in),
    .word_next (word_next),
    .word_done (word_done)
  );

  // Session sequencing, address/count bookkeeping and checksum accumulation.
  // Outputs are derived from the next state so they are registered with it.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    chk_d       = chk_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pack_clear  = 1'b0;
    pack_shift  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          remain_d   = word_count;
          chk_d      = '0;
          err_d      = 1'b0;
          pack_clear = 1'b1;
          state_d    = (word_count == '0) ? S_CHECK : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          pack_shift = 1'b1;
          chk_d      = chk_q ^ byte_in;
          if (word_done) begin
            mem_addr_d  = addr_q;
            mem_wdata_d = word_next;
            state_d     = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d   = addr_q + ADDR_W'(1);
        remain_d = remain_q - CNT_W'(1);
        state_d  = (remain_d != '0) ? S_LOAD : S_CHECK;
      end
      S_CHECK: begin
        if (accept) begin
          err_d   = (byte_in != chk_q);
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    byte_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
    mem_we_d     = (state_d == S_WRITE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FINISH);
  end

  // State and registered outputs; reset aborts any session in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      chk_q        <= '0;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      chk_q        <= chk_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes and
// session results; an independent monitor pops and compares them.
module tb_prog_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  wr_t  exp_wr[$];
  bit   exp_err[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit   mon_en   = 1'b0;
  logic prev_done = 1'b0;

  prog_loader #(.ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", {31'd0, mem_we}, 32'd0);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("write_addr", {16'd0, mem_addr}, {16'd0, w.addr});
          check("write_data", mem_wdata, w.data);
          check("busy_during_write", {31'd0, busy}, 32'd1);
        end
      end
      if (done) begin
        if (prev_done) check("done_one_cycle", {31'd0, prev_done}, 32'd0);
        if (exp_err.size() == 0) begin
          check("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          bit e;
          e = exp_err.pop_front();
          check("err_at_done", {31'd0, err}, {31'd0, e});
        end
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int unsigned n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_start(input logic [15:0] base, input logic [15:0] wc);
    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    word_count = wc;
    @(negedge clk);
    start      = 1'b0;
    base_addr  = 16'($urandom);
    word_count = 16'($urandom);
  endtask

  // Offers one byte after 'gap' idle cycles; optionally pulses a stray start in the gap.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit mid_start);
    int unsigned n = 0;
    bit got = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      start      = (mid_start && i == 0);
      base_addr  = 16'($urandom);
      word_count = 16'($urandom_range(0, 5));
    end
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_in    = b;
    while (!got && n < 200) begin
      if (byte_ready) begin
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    #1;
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
    if (!got) check("byte_accept_timeout", {31'd0, got}, 32'd1);
  endtask

  // Reference: words are consecutive 4-byte big-endian groups at base+i (mod 2^16);
  // err is set iff the checksum byte differs from the XOR of all data bytes.
  task automatic session(input logic [15:0] base, input logic [15:0] wc, input bq_t data,
                         input logic [7:0] chk, input int gap, input bit mid);
    logic [7:0] x = 8'd0;
    for (int i = 0; i < int'(wc); i++) begin
      wr_t w;
      w.addr = 16'((32'(base) + i) % 65536);
      w.data = {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]};
      exp_wr.push_back(w);
    end
    foreach (data[i]) x ^= data[i];
    exp_err.push_back(chk != x);
    do_start(base, wc);
    foreach (data[i]) begin
      send_byte(data[i], gap, mid && (i == 1 || i == 5));
      if (i % 4 == 3) begin
        @(negedge clk);
        check("we_after_4th_byte", {31'd0, mem_we}, 32'd1);
      end
    end
    send_byte(chk, gap, 1'b0);
    @(negedge clk);
    check("done_after_chk", {31'd0, done}, 32'd1);
    wait_idle();
  endtask

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic logic [7:0] xor_of(input bq_t q);
    logic [7:0] x = 8'd0;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t ref_stream;
    ref_stream = '{8'h20, 8'h01, 8'h00, 8'h02, 8'h00, 8'h22, 8'h18, 8'h20};
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    byte_in = '0; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Two-word reference stream with correct checksum.
    session(16'h0010, 16'd2, ref_stream, xor_of(ref_stream), 0, 1'b0);
    check("err_clear_good", {31'd0, err}, 32'd0);
    // Same stream with wrong checksum; err holds, then a new start clears it.
    session(16'h0010, 16'd2, ref_stream, 8'h00, 0, 1'b0);
    check("err_held", {31'd0, err}, 32'd1);
    do_start(16'h0000, 16'd0);
    check("err_cleared_by_start", {31'd0, err}, 32'd0);
    exp_err.push_back(1'b0);
    send_byte(8'h00, 0, 1'b0);
    @(negedge clk);
    check("zero_words_done", {31'd0, done}, 32'd1);
    wait_idle();
    // Zero-word session with no writes.
    session(16'h1234, 16'd0, '{}, 8'h00, 0, 1'b0);
    // Address wrap.
    session(16'hFFFF, 16'd2, ref_stream, xor_of(ref_stream), 0, 1'b0);
    // Gapped bytes plus stray starts while busy.
    session(16'h0010, 16'd2, ref_stream, xor_of(ref_stream), 3, 1'b1);

    // Leave err set, then reset after two bytes of the first word.
    session(16'h0200, 16'd1, '{8'h11, 8'h22, 8'h33, 8'h44}, 8'hFF, 0, 1'b0);
    do_start(16'h0040, 16'd2);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("abort_mem_we", {31'd0, mem_we}, 32'd0);
    check("abort_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("abort_mem_wdata", mem_wdata, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    repeat (5) @(negedge clk);
    session(16'h0040, 16'd1, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, xor_of('{8'hDE, 8'hAD, 8'hBE, 8'hEF}), 0, 1'b0);

    // Randomized sessions.
    for (int s = 0; s < 10; s++) begin
      bq_t d;
      int wc;
      logic [7:0] c;
      wc = $urandom_range(0, 3);
      d  = rand_bytes(4 * wc);
      c  = xor_of(d);
      if ($urandom_range(0, 1) == 1) c ^= 8'($urandom_range(1, 255));
      session(16'($urandom), 16'(wc), d, c, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    check("writes_outstanding", exp_wr.size(), 32'd0);
    check("sessions_outstanding", exp_err.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
